// File: rtl/ha_sched_pkg.sv
// Shared types and helpers for the half-adder-array multiplier scheduler.
// Row reduction weights: t[i] of row k has weight 2k+i, b[i] has weight 2k+i+2.
package ha_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } ha_sched_state_e;

  localparam int HA_ROWS  = 4;
  localparam int HA_B_W   = 7;
  localparam int HA_T_W   = 9;
  localparam int HA_P_W   = 16;
  localparam int HA_ROW_W = 10;

  // Combine one row pair into its 10-bit partial value (row weight applied later).
  function automatic logic [HA_ROW_W-1:0] row_value(input logic [HA_B_W-1:0] b,
                                                    input logic [HA_T_W-1:0] t);
    return HA_ROW_W'(t) + (HA_ROW_W'(b) << 2);
  endfunction

endpackage

// File: rtl/ha_array_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and the
// pointer moves only when the grant is actually taken (advance).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int o = 0; o < N; o++) begin
      j = (int'(ptr) + o) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

  // Move the search start just past the winner whenever a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/ha_array_mul_scheduler.sv
// Shares one external 8x8 ha_array multiplier between NUM_REQ requesters.
// Grants round-robin, drives the winner's operands to the array, reduces the
// four b/t row pairs one per cycle with a single adder, returns the product.
// Optional feature macro: HA_SCHED_ZERO_SKIP_EN (zero operand goes straight
// from grant to RESP with a zero product).
//
// state | meaning
// IDLE  | waiting for a request; grant cycle
// LOAD  | operands registered, array settling
// ACC   | accumulate row k (k = 0..3)
// RESP  | product presented until rsp_ready
module ha_array_mul_scheduler
  import ha_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*8-1:0]      req_x,
  input  logic [NUM_REQ*8-1:0]      req_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IW-1:0]             rsp_id,
  output logic [HA_P_W-1:0]         rsp_p,
  output logic [7:0]                arr_x,
  output logic [7:0]                arr_y,
  input  logic [HA_ROWS*HA_B_W-1:0] arr_b,
  input  logic [HA_ROWS*HA_T_W-1:0] arr_t
);

  ha_sched_state_e state, state_next;

  logic [NUM_REQ-1:0] grant_vec;
  logic [IW-1:0]      win_idx;
  logic [7:0]         win_x, win_y;
  logic               grant_fire;
  logic               skip;

  logic [IW-1:0]      id_q;
  logic [HA_P_W-1:0]  acc_q;
  logic [1:0]         k_q;

  logic [HA_B_W-1:0]  b_k;
  logic [HA_T_W-1:0]  t_k;
  logic [HA_P_W-1:0]  row_sh;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (grant_fire),
    .grant   (grant_vec),
    .index   (win_idx)
  );

  // Winner operands, zero detection, and the current row's weighted value.
  always_comb begin
    win_x      = req_x[int'(win_idx)*8 +: 8];
    win_y      = req_y[int'(win_idx)*8 +: 8];
    grant_fire = (state == IDLE) && (|req_valid);
`ifdef HA_SCHED_ZERO_SKIP_EN
    skip       = (win_x == 8'd0) || (win_y == 8'd0);
`else
    skip       = 1'b0;
`endif
    b_k        = arr_b[int'(k_q)*HA_B_W +: HA_B_W];
    t_k        = arr_t[int'(k_q)*HA_T_W +: HA_T_W];
    row_sh     = HA_P_W'(row_value(b_k, t_k)) << {k_q, 1'b0};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = grant_vec;
          state_next = skip ? RESP : LOAD;
        end
      end
      LOAD: state_next = ACC;
      ACC: begin
        if (k_q == 2'(HA_ROWS - 1)) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch at grant, row accumulation during ACC.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_x <= '0;
      arr_y <= '0;
      id_q  <= '0;
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            arr_x <= win_x;
            arr_y <= win_y;
            id_q  <= win_idx;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        ACC: begin
          acc_q <= acc_q + row_sh;
          k_q   <= k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_p  = acc_q;
  assign rsp_id = id_q;

endmodule
